uart_tx_framer: RTL
===================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload bits per frame, legal range 5..16.
REQ-002 SHALL have parameter MSB_FIRST, default 0: 0 sends bit 0 first, 1 sends bit DATA_WIDTH-1 first.
REQ-003 SHALL have parameter PARITY_EN, default 1: 1 inserts a parity bit after the payload, 0 omits it.
REQ-004 SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
REQ-005 SHALL have parameter STOP_BITS, default 1, number of stop bits, legal values 1 or 2.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port p_data  input  DATA_WIDTH  parallel payload, sampled only on an accept cycle.
REQ-009 SHALL have port data_valid  input  1  request to send p_data.
REQ-010 SHALL have port bit_tick  input  1  one-cycle bit-period strobe from the baud generator.
REQ-011 SHALL have port ready  output  1  high when a new word can be accepted.
REQ-012 SHALL have port busy  output  1  high while a frame is on the line.
REQ-013 SHALL have port ser_data  output  1  registered serial line; idle level 1.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a frame completes.

Function
REQ-015 SHALL implement a state machine with states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL define accept as a rising edge where state=IDLE and data_valid=1. bit_tick is ignored in IDLE.
REQ-017 SHALL, on accept, latch p_data into a DATA_WIDTH shift register, latch the parity bit, and enter START on the same edge.
- Parity bit: XOR of p_data, XORed with PARITY_ODD.
REQ-018 SHALL hold ready=1 exactly when state=IDLE, and busy=1 exactly when state is not IDLE.
REQ-019 SHALL drive ser_data from a register as follows:
- IDLE: 1
- START: 0
- DATA: current shift-register output bit (bit 0 if MSB_FIRST=0, else bit DATA_WIDTH-1)
- PARITY: latched parity bit
- STOP: 1
REQ-020 SHALL ignore data_valid and p_data while busy=1. No queuing; the latched word is unaffected.
REQ-021 SHALL advance the frame only on cycles where state is not IDLE and bit_tick=1:
- START->DATA.
- In DATA, shift one position toward the output end and increment a bit counter of width clog2(DATA_WIDTH)+1.
- Leave DATA when the counter reaches DATA_WIDTH-1 on a tick: go to PARITY if PARITY_EN=1, else to STOP.
- PARITY->STOP.
- In STOP, leave on the STOP_BITS-th tick.
REQ-022 SHALL hold state, counter and ser_data unchanged on cycles with bit_tick=0.
REQ-023 SHALL, on the final STOP tick, enter IDLE and assert done for exactly the next cycle (done coincides with the first ready=1 cycle).
REQ-024 SHALL allow a new accept on the cycle where done=1, giving back-to-back frames with one idle cycle at ser_data=1.
REQ-025 SHALL make a frame last 1+DATA_WIDTH+PARITY_EN+STOP_BITS bit periods, each period one bit_tick interval long.
REQ-026 SHALL treat bit_tick asserted continuously as one bit period per clock cycle.

Reset
REQ-027 SHALL, while rst=1, force state=IDLE, shift register=0, counter=0, parity register=0, ser_data=1, ready=1, busy=0, done=0, independent of clk.
REQ-028 SHALL abort any frame in progress on rst assertion, with no done pulse. After release, the first accept starts a fresh frame.

Verification
REQ-029 SHALL pass this scenario: defaults, bit_tick tied 1, p_data=0xA5 accepted -> ser_data sequence 0,1,0,1,0,0,1,0,1,0(parity even),1(stop); done pulses on the cycle after the stop bit; total 11 busy cycles.
REQ-030 SHALL pass this scenario: MSB_FIRST=1, PARITY_ODD=1, STOP_BITS=2, p_data=0x81 -> ser_data 0,1,0,0,0,0,0,0,1,1(odd parity),1,1.
REQ-031 SHALL pass this scenario: bit_tick every 16 cycles, p_data=0x3C -> each bit held exactly 16 cycles; data_valid=1 with p_data=0xFF mid-frame leaves the frame bits unchanged.
REQ-032 SHALL pass this scenario: PARITY_EN=0, DATA_WIDTH=5, p_data=5'h1F -> ser_data 0,1,1,1,1,1,1 (7 bit periods).
REQ-033 SHALL pass this scenario: rst pulsed during DATA bit 3 -> ser_data=1, busy=0 asynchronously, no done; the next accept of 0x00 produces a full fresh frame.
REQ-034 SHALL pass this scenario: data_valid held high, p_data=0x55 then 0xAA on the done cycle -> two complete frames separated by exactly one idle cycle at ser_data=1.

Source files
------------

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serialises one parallel word per request into an asynchronous
// serial frame: a start bit, DATA_WIDTH payload bits, an optional parity bit and
// one or two stop bits. The frame advances only on bit_tick, so the baud rate is
// set entirely by the external baud generator.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-high reset
//   p_data     - parallel payload, sampled only when a word is accepted
//   data_valid - request to send p_data (ignored while busy)
//   bit_tick   - one-cycle bit-period strobe (ignored while idle)
//   ready      - high when a new word can be accepted (idle)
//   busy       - high while a frame is on the line
//   ser_data   - registered serial output, idles at 1
//   done       - one-cycle pulse on the first idle cycle after a frame
module uart_tx_framer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MSB_FIRST  = 0,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  bit_tick,
    output logic                  ready,
    output logic                  busy,
    output logic                  ser_data,
    output logic                  done
);

    localparam int unsigned CntWidth = $clog2(DATA_WIDTH) + 1;
    localparam logic [CntWidth-1:0] LastBit  = CntWidth'(DATA_WIDTH - 1);
    localparam logic [CntWidth-1:0] LastStop = CntWidth'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  par_q, par_d;
    logic                  ser_q, ser_d;
    logic                  done_q, done_d;

    // Next-state, datapath and the value ser_data must show in the next state.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (data_valid) begin
                    shift_d = p_data;
                    par_d   = (^p_data) ^ (PARITY_ODD != 0);
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_tick) begin
                    // Move the next payload bit onto the output end.
                    if (MSB_FIRST != 0) begin
                        shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    end
                    if (cnt_q == LastBit) begin
                        cnt_d   = '0;
                        state_d = (PARITY_EN != 0) ? StParity : StStop;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (bit_tick) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                // The bit counter is reused to count stop bits.
                if (bit_tick) begin
                    if (cnt_q == LastStop) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        unique case (state_d)
            StIdle:   ser_d = 1'b1;
            StStart:  ser_d = 1'b0;
            StData:   ser_d = (MSB_FIRST != 0) ? shift_d[DATA_WIDTH-1] : shift_d[0];
            StParity: ser_d = par_d;
            StStop:   ser_d = 1'b1;
            default:  ser_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            ser_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
        end
    end

    assign ready    = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign ser_data = ser_q;
    assign done     = done_q;

endmodule
